// File: rtl/csel_pkg.sv
// -----------------------------------------------------------------------------
// csel_pkg
// Shared constants for the pipelined carry-select adder: default geometry and
// an elaboration-time check of the geometry rules. A WIDTH must split into
// whole BLK-bit blocks, and the block count must split into whole stages of
// STAGE_BLKS blocks.
// -----------------------------------------------------------------------------
package csel_pkg;

   localparam int CSEL_WIDTH      = 32;
   localparam int CSEL_BLK        = 4;
   localparam int CSEL_STAGE_BLKS = 2;

   // 1 when the (width, blk, stage_blks) set yields whole blocks and stages.
   function automatic bit csel_cfg_ok(input int width, input int blk, input int stage_blks);
      if (blk < 1 || stage_blks < 1 || width < blk) return 1'b0;
      if ((width % blk) != 0) return 1'b0;
      return ((width / blk) % stage_blks) == 0;
   endfunction

endpackage

// File: rtl/csel_adder_pipe_if.sv
// -----------------------------------------------------------------------------
// csel_adder_pipe_if
// Operand/result handshake bundle for csel_adder_pipe.
//   in_valid/in_ready   : operand transfer (in_a, in_b, in_cin, in_sub)
//   out_valid/out_ready : result transfer (out_sum, out_cout)
//   out_zero/out_ovf    : result flags, present only with CSEL_ADDER_FLAGS_EN
// master = operand source / result sink, slave = the adder.
// -----------------------------------------------------------------------------
interface csel_adder_pipe_if
   import csel_pkg::*;
#(
   parameter int WIDTH = CSEL_WIDTH
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             in_cin;
   logic             in_sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_sum;
   logic             out_cout;
`ifdef CSEL_ADDER_FLAGS_EN
   logic             out_zero;
   logic             out_ovf;

   modport master (output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
                   input  in_ready, out_valid, out_sum, out_cout, out_zero, out_ovf);
   modport slave  (input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
                   output in_ready, out_valid, out_sum, out_cout, out_zero, out_ovf);
`else
   modport master (output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
                   input  in_ready, out_valid, out_sum, out_cout);
   modport slave  (input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
                   output in_ready, out_valid, out_sum, out_cout);
`endif
endinterface

// File: rtl/csel_block.sv
// -----------------------------------------------------------------------------
// csel_block
// Purely combinational BLK-bit carry-select block. Two ripple chains run in
// parallel, one assuming carry-in 0 and one assuming 1; the real carry-in then
// picks each sum bit and the carry-out.
//   a, b : operand slices      cin  : incoming carry
//   sum  : selected sum slice  cout : selected carry-out
// -----------------------------------------------------------------------------
module csel_block #(
   parameter int BLK = 4
) (
   input  logic [BLK-1:0] a,
   input  logic [BLK-1:0] b,
   input  logic           cin,
   output logic [BLK-1:0] sum,
   output logic           cout
);

   logic [BLK-1:0] w_s0, w_s1;
   logic [BLK:0]   w_c0, w_c1;

   always_comb begin
      w_s0    = '0;
      w_s1    = '0;
      w_c0    = '0;
      w_c1    = '0;
      w_c1[0] = 1'b1;
      for (int i = 0; i < BLK; i++) begin
         w_s0[i]   = a[i] ^ b[i] ^ w_c0[i];
         w_c0[i+1] = (a[i] & b[i]) | (w_c0[i] & (a[i] ^ b[i]));
         w_s1[i]   = a[i] ^ b[i] ^ w_c1[i];
         w_c1[i+1] = (a[i] & b[i]) | (w_c1[i] & (a[i] ^ b[i]));
      end
   end

   for (genvar i = 0; i < BLK; i++) begin : g_mux
      assign sum[i] = cin ? w_s1[i] : w_s0[i];
   end

   assign cout = cin ? w_c1[BLK] : w_c0[BLK];

endmodule

// File: rtl/csel_adder_pipe.sv
// -----------------------------------------------------------------------------
// csel_adder_pipe
// Pipelined carry-select adder/subtractor. WIDTH bits are cut into BLK-bit
// csel_block slices; each pipeline stage resolves STAGE_BLKS of them, so the
// latency is NUM_BLK/STAGE_BLKS cycles at one result per cycle.
//   clk, rst : clock, synchronous active-high reset
//   ifc      : csel_adder_pipe_if.slave (operand and result handshakes)
// Optional: define CSEL_ADDER_FLAGS_EN to add out_zero / out_ovf.
//
// Every stage register moves only when adv = !out_valid || out_ready, so a
// stalled output freezes the whole chain, bubbles included. in_ready is adv.
// -----------------------------------------------------------------------------
module csel_adder_pipe
   import csel_pkg::*;
#(
   parameter int WIDTH      = CSEL_WIDTH,
   parameter int BLK        = CSEL_BLK,
   parameter int STAGE_BLKS = CSEL_STAGE_BLKS
) (
   input  logic               clk,
   input  logic               rst,
   csel_adder_pipe_if.slave   ifc
);

   localparam int NUM_BLK = WIDTH / BLK;
   localparam int NUM_STG = NUM_BLK / STAGE_BLKS;
   localparam int SW      = STAGE_BLKS * BLK;   // bits resolved per stage
   localparam int LS      = NUM_STG - 1;

   if (!csel_cfg_ok(WIDTH, BLK, STAGE_BLKS)) begin : g_cfg_err
      $error("csel_adder_pipe: WIDTH must be a multiple of BLK and WIDTH/BLK a multiple of STAGE_BLKS");
   end

   logic w_adv;
   assign w_adv = !g_stg[LS].r_v || ifc.out_ready;

   // Stage s consumes operand bits [s*SW +: SW]. Its incoming operands hold
   // only the bits not yet added (RW wide), its outgoing sum holds every bit
   // finished so far, so register widths shrink/grow along the chain.
   for (genvar s = 0; s < NUM_STG; s++) begin : g_stg
      localparam int LO = s * SW;
      localparam int RW = WIDTH - LO;

      logic [RW-1:0]    w_a, w_b;
      logic             w_c, w_v;
      logic [SW-1:0]    w_s;
      logic [LO+SW-1:0] w_nsum;
      logic             r_v, r_c;
      logic [LO+SW-1:0] r_sum;

      if (s == 0) begin : g_in
         // Subtract folds into the add here: invert B, force carry-in.
         assign w_a    = ifc.in_a;
         assign w_b    = ifc.in_sub ? ~ifc.in_b : ifc.in_b;
         assign w_c    = ifc.in_sub | ifc.in_cin;
         assign w_v    = ifc.in_valid;
         assign w_nsum = w_s;
      end else begin : g_mid
         assign w_a    = g_stg[s-1].g_fwd.r_a;
         assign w_b    = g_stg[s-1].g_fwd.r_b;
         assign w_c    = g_stg[s-1].r_c;
         assign w_v    = g_stg[s-1].r_v;
         assign w_nsum = {w_s, g_stg[s-1].r_sum};
      end

      // Carry ripples block to block through the select muxes only.
      for (genvar k = 0; k < STAGE_BLKS; k++) begin : g_blk
         logic w_ci, w_co;
         if (k == 0) begin : g_c0
            assign w_ci = w_c;
         end else begin : g_cn
            assign w_ci = g_blk[k-1].w_co;
         end
         csel_block #(.BLK(BLK)) u_blk (
            .a    (w_a[k*BLK +: BLK]),
            .b    (w_b[k*BLK +: BLK]),
            .cin  (w_ci),
            .sum  (w_s[k*BLK +: BLK]),
            .cout (w_co)
         );
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            r_v   <= 1'b0;
            r_c   <= 1'b0;
            r_sum <= '0;
         end else if (w_adv) begin
            r_v   <= w_v;
            r_c   <= g_blk[STAGE_BLKS-1].w_co;
            r_sum <= w_nsum;
         end
      end

      if (RW > SW) begin : g_fwd
         logic [RW-SW-1:0] r_a, r_b;
         always_ff @(posedge clk) begin
            if (rst) begin
               r_a <= '0;
               r_b <= '0;
            end else if (w_adv) begin
               r_a <= w_a[RW-1:SW];
               r_b <= w_b[RW-1:SW];
            end
         end
      end
   end

   assign ifc.in_ready  = w_adv;
   assign ifc.out_valid = g_stg[LS].r_v;
   assign ifc.out_sum   = g_stg[LS].r_sum;
   assign ifc.out_cout  = g_stg[LS].r_c;

`ifdef CSEL_ADDER_FLAGS_EN
   // The last stage still sees the operand MSBs (B already inverted), which
   // is all the signed overflow test needs.
   logic w_zero, w_ovf, r_zero, r_ovf;
   assign w_zero = ~|g_stg[LS].w_nsum;
   assign w_ovf  = (g_stg[LS].w_a[SW-1] == g_stg[LS].w_b[SW-1]) &&
                   (g_stg[LS].w_nsum[WIDTH-1] != g_stg[LS].w_a[SW-1]);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_zero <= 1'b0;
         r_ovf  <= 1'b0;
      end else if (w_adv) begin
         r_zero <= w_zero;
         r_ovf  <= w_ovf;
      end
   end

   assign ifc.out_zero = r_zero;
   assign ifc.out_ovf  = r_ovf;
`endif

endmodule

// File: tb/tb_csel_adder_pipe.sv
// -----------------------------------------------------------------------------
// tb_csel_adder_pipe
// Self-checking bench for csel_adder_pipe at WIDTH=16, BLK=4, STAGE_BLKS=2
// (latency 2). Inputs change on the falling edge; outputs are read there too.
// Define CSEL_ADDER_FLAGS_EN to also check out_zero / out_ovf.
// -----------------------------------------------------------------------------
module tb_csel_adder_pipe;

   localparam int W = 16;

   typedef struct packed {
      logic [W-1:0] sum;
      logic         cout;
      logic         zero;
      logic         ovf;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_pass  = 0;
   int   n_total = 0;

   always #5 clk = ~clk;

   csel_adder_pipe_if #(.WIDTH(W)) ifc ();

   csel_adder_pipe #(.WIDTH(W), .BLK(4), .STAGE_BLKS(2)) dut (
      .clk (clk),
      .rst (rst),
      .ifc (ifc)
   );

   // Behavioural reference: plain A+B+cin, or A-B with no-borrow carry.
   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic cin, input logic sub);
      exp_t       e;
      logic [W:0] t;
      if (sub) begin
         e.sum  = a - b;
         e.cout = (a >= b);
         e.ovf  = (a[W-1] != b[W-1]) && (e.sum[W-1] != a[W-1]);
      end else begin
         t      = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
         e.sum  = t[W-1:0];
         e.cout = t[W];
         e.ovf  = (a[W-1] == b[W-1]) && (e.sum[W-1] != a[W-1]);
      end
      e.zero = (e.sum == '0);
      return e;
   endfunction

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Sends one operand pair into an empty pipe and returns the result and the
   // number of rising edges from acceptance to out_valid.
   task automatic drive_one(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic cin, input logic sub,
                            output exp_t got, output int lat);
      ifc.in_a      = a;
      ifc.in_b      = b;
      ifc.in_cin    = cin;
      ifc.in_sub    = sub;
      ifc.in_valid  = 1'b1;
      ifc.out_ready = 1'b1;
      tick();
      ifc.in_valid = 1'b0;
      lat = 1;
      while (!ifc.out_valid && lat < 10) begin
         tick();
         lat++;
      end
      got.sum  = ifc.out_sum;
      got.cout = ifc.out_cout;
`ifdef CSEL_ADDER_FLAGS_EN
      got.zero = ifc.out_zero;
      got.ovf  = ifc.out_ovf;
`else
      got.zero = 1'b0;
      got.ovf  = 1'b0;
`endif
      tick();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      ifc.in_valid  = 1'b0;
      ifc.out_ready = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      #1;
      n_total++; if (ifc.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", ifc.out_valid); else n_pass++;
      n_total++; if (ifc.out_sum !== 16'h0000) $display("FAIL reset_out_sum: got %h want 0000", ifc.out_sum); else n_pass++;
      n_total++; if (ifc.out_cout !== 1'b0) $display("FAIL reset_out_cout: got %b want 0", ifc.out_cout); else n_pass++;
      n_total++; if (ifc.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", ifc.in_ready); else n_pass++;
      @(negedge clk);
   endtask

   task automatic test_add();
      exp_t got;
      int   lat;
      drive_one(16'hFFFF, 16'h0001, 1'b0, 1'b0, got, lat);
      n_total++; if (lat !== 2) $display("FAIL add_wrap_latency: got %0d want 2", lat); else n_pass++;
      n_total++; if (got.sum !== 16'h0000) $display("FAIL add_wrap_sum: got %h want 0000", got.sum); else n_pass++;
      n_total++; if (got.cout !== 1'b1) $display("FAIL add_wrap_cout: got %b want 1", got.cout); else n_pass++;
      drive_one(16'h1234, 16'h4321, 1'b1, 1'b0, got, lat);
      n_total++; if (got.sum !== 16'h5556) $display("FAIL add_cin_sum: got %h want 5556", got.sum); else n_pass++;
      n_total++; if (got.cout !== 1'b0) $display("FAIL add_cin_cout: got %b want 0", got.cout); else n_pass++;
   endtask

   task automatic test_sub();
      exp_t got;
      int   lat;
      drive_one(16'h0005, 16'h0007, 1'b0, 1'b1, got, lat);
      n_total++; if (got.sum !== 16'hFFFE) $display("FAIL sub_neg_sum: got %h want fffe", got.sum); else n_pass++;
      n_total++; if (got.cout !== 1'b0) $display("FAIL sub_neg_cout: got %b want 0", got.cout); else n_pass++;
      // cin=1 here must be ignored.
      drive_one(16'h1234, 16'h0234, 1'b1, 1'b1, got, lat);
      n_total++; if (got.sum !== 16'h1000) $display("FAIL sub_pos_sum: got %h want 1000", got.sum); else n_pass++;
      n_total++; if (got.cout !== 1'b1) $display("FAIL sub_pos_cout: got %b want 1", got.cout); else n_pass++;
   endtask

`ifdef CSEL_ADDER_FLAGS_EN
   task automatic test_flags();
      exp_t got;
      int   lat;
      drive_one(16'h7FFF, 16'h0001, 1'b0, 1'b0, got, lat);
      n_total++; if (got.ovf !== 1'b1) $display("FAIL flags_pos_ovf: got %b want 1", got.ovf); else n_pass++;
      n_total++; if (got.zero !== 1'b0) $display("FAIL flags_pos_zero: got %b want 0", got.zero); else n_pass++;
      drive_one(16'h8000, 16'h8000, 1'b0, 1'b0, got, lat);
      n_total++; if (got.sum !== 16'h0000) $display("FAIL flags_neg_sum: got %h want 0000", got.sum); else n_pass++;
      n_total++; if (got.cout !== 1'b1) $display("FAIL flags_neg_cout: got %b want 1", got.cout); else n_pass++;
      n_total++; if (got.ovf !== 1'b1) $display("FAIL flags_neg_ovf: got %b want 1", got.ovf); else n_pass++;
      n_total++; if (got.zero !== 1'b1) $display("FAIL flags_neg_zero: got %b want 1", got.zero); else n_pass++;
   endtask
`endif

   task automatic test_back_to_back();
      logic [W-1:0] q[$];
      logic [W-1:0] e;
      ifc.in_sub    = 1'b0;
      ifc.in_cin    = 1'b0;
      ifc.out_ready = 1'b1;
      for (int i = 1; i <= 2; i++) begin
         ifc.in_a = W'(i); ifc.in_b = W'(i); ifc.in_valid = 1'b1;
         q.push_back(W'(2 * i));
         tick();
      end
      // First result is now valid; stall for two cycles with 3+3 waiting.
      ifc.in_a = 16'd3; ifc.in_b = 16'd3; ifc.out_ready = 1'b0;
      q.push_back(16'd6);
      #1;
      n_total++; if (ifc.in_ready !== 1'b0) $display("FAIL b2b_stall_in_ready: got %b want 0", ifc.in_ready); else n_pass++;
      n_total++; if (ifc.out_valid !== 1'b1) $display("FAIL b2b_stall_valid: got %b want 1", ifc.out_valid); else n_pass++;
      for (int c = 0; c < 2; c++) begin
         tick();
         if (c == 1) begin ifc.out_ready = 1'b1; #1; end
         n_total++; if (ifc.out_sum !== 16'h0002) $display("FAIL b2b_stall_hold: cycle %0d got %h want 0002", c, ifc.out_sum); else n_pass++;
         n_total++; if (ifc.in_ready !== (c == 1)) $display("FAIL b2b_in_ready: cycle %0d got %b want %b", c, ifc.in_ready, c == 1); else n_pass++;
      end
      for (int i = 0; i < 3; i++) begin
         e = q.pop_front();
         n_total++; if (ifc.out_valid !== 1'b1 || ifc.out_sum !== e) $display("FAIL b2b_order: slot %0d got v=%b %h want v=1 %h", i, ifc.out_valid, ifc.out_sum, e); else n_pass++;
         tick();
         ifc.in_valid = 1'b0;
      end
      n_total++; if (ifc.out_valid !== 1'b0) $display("FAIL b2b_drain: got out_valid %b want 0", ifc.out_valid); else n_pass++;
   endtask

   task automatic test_reset_mid();
      logic seen = 1'b0;
      ifc.out_ready = 1'b1;
      ifc.in_sub    = 1'b0;
      ifc.in_cin    = 1'b0;
      ifc.in_a = 16'h1111; ifc.in_b = 16'h1111; ifc.in_valid = 1'b1;
      tick();
      ifc.in_a = 16'h2222; ifc.in_b = 16'h2222;
      tick();
      ifc.in_valid = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      n_total++; if (ifc.out_valid !== 1'b0) $display("FAIL rstmid_valid: got %b want 0", ifc.out_valid); else n_pass++;
      n_total++; if (ifc.out_sum !== 16'h0000) $display("FAIL rstmid_sum: got %h want 0000", ifc.out_sum); else n_pass++;
      n_total++; if (ifc.in_ready !== 1'b1) $display("FAIL rstmid_in_ready: got %b want 1", ifc.in_ready); else n_pass++;
      for (int c = 0; c < 6; c++) begin
         seen = seen | ifc.out_valid;
         tick();
      end
      n_total++; if (seen !== 1'b0) $display("FAIL rstmid_ghost: pre-reset result appeared (seen=%b)", seen); else n_pass++;
   endtask

   task automatic test_random();
      exp_t q[$];
      exp_t e;
      int   n_acc = 0;
      int   cyc   = 0;
      while ((n_acc < 10000 || q.size() != 0) && cyc < 60000) begin
         ifc.in_valid  = (n_acc < 10000) && ($urandom_range(0, 9) < 7);
         ifc.in_a      = W'($urandom);
         ifc.in_b      = W'($urandom);
         ifc.in_cin    = 1'($urandom);
         ifc.in_sub    = 1'($urandom);
         ifc.out_ready = (n_acc >= 10000) || ($urandom_range(0, 9) < 7);
         #1;
         if (ifc.out_valid && ifc.out_ready) begin
            n_total++;
            if (q.size() == 0) begin
               $display("FAIL rand_extra: unexpected result %h at cycle %0d", ifc.out_sum, cyc);
            end else begin
               e = q.pop_front();
`ifdef CSEL_ADDER_FLAGS_EN
               if ({ifc.out_sum, ifc.out_cout, ifc.out_zero, ifc.out_ovf} !== e)
                  $display("FAIL rand_result: got %h/%b z%b o%b want %h/%b z%b o%b", ifc.out_sum, ifc.out_cout, ifc.out_zero, ifc.out_ovf, e.sum, e.cout, e.zero, e.ovf);
               else n_pass++;
`else
               if ({ifc.out_sum, ifc.out_cout} !== {e.sum, e.cout})
                  $display("FAIL rand_result: got %h/%b want %h/%b", ifc.out_sum, ifc.out_cout, e.sum, e.cout);
               else n_pass++;
`endif
            end
         end
         if (ifc.in_valid && ifc.in_ready) begin
            q.push_back(model(ifc.in_a, ifc.in_b, ifc.in_cin, ifc.in_sub));
            n_acc++;
         end
         tick();
         cyc++;
      end
      ifc.in_valid = 1'b0;
      n_total++; if (n_acc != 10000 || q.size() != 0) $display("FAIL rand_lost: accepted %0d want 10000, outstanding %0d want 0", n_acc, q.size()); else n_pass++;
   endtask

   initial begin
      ifc.in_valid  = 1'b0;
      ifc.in_a      = '0;
      ifc.in_b      = '0;
      ifc.in_cin    = 1'b0;
      ifc.in_sub    = 1'b0;
      ifc.out_ready = 1'b0;
      @(negedge clk);
      test_reset();
      test_add();
      test_sub();
`ifdef CSEL_ADDER_FLAGS_EN
      test_flags();
`endif
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
